// File: rtl/spi_pkg.sv
// Shared frame layout, register map and FSM state encoding for the SPI front end.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;

  localparam logic [6:0] ADDR_EN_OUT_7_0    = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8   = 7'h01;
  localparam logic [6:0] ADDR_DATA_OUT_7_0  = 7'h02;
  localparam logic [6:0] ADDR_DATA_OUT_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY      = 7'h04;

  localparam logic [4:0] COUNT_FULL    = 5'd16;
  localparam logic [4:0] COUNT_OVERRUN = 5'd17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin followed by a level/rise/fall edge detector.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev   <= level;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 frame receiver turning legal 16-bit write frames into one-cycle register writes.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse for short, overrun and out-of-range frames.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic       valid,
  output logic       read_write,
  output logic [6:0] addr,
  output logic [7:0] data,
`ifdef SPI_FRAME_ERR_EN
  output logic       frame_err,
`endif
  output logic       busy
);

  logic sclk_level_unused, sclk_rise, sclk_fall_unused;
  logic ncs_level, ncs_rise, ncs_fall_unused;
  logic copi_level, copi_rise_unused, copi_fall_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .pin(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall_unused)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .pin(copi),
    .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  state_t                  state;
  logic [FRAME_BITS-1:0]   shift;
  logic [4:0]              count;
  logic                    full_frame;
  logic                    legal;
  logic                    read_frame;

  assign full_frame = (count == COUNT_FULL);
  assign legal      = full_frame && shift[RW_BIT] && (shift[ADDR_MSB:ADDR_LSB] <= MAX_ADDR);
  assign read_frame = full_frame && !shift[RW_BIT];
  assign busy       = ~ncs_level;

  // Commit is registered on the edge that leaves SHIFT, so valid is high during CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      count      <= '0;
      valid      <= 1'b0;
      read_write <= 1'b0;
      addr       <= '0;
      data       <= '0;
`ifdef SPI_FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          shift <= '0;
          count <= '0;
          if (!ncs_level) state <= SHIFT;
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= CHECK;
            if (legal) begin
              valid      <= 1'b1;
              read_write <= shift[RW_BIT];
              addr       <= shift[ADDR_MSB:ADDR_LSB];
              data       <= shift[DATA_MSB:0];
            end
`ifdef SPI_FRAME_ERR_EN
            frame_err <= !legal && !read_frame;
`endif
          end else if (sclk_rise) begin
            shift <= {shift[FRAME_BITS-2:0], copi_level};
            if (count != COUNT_OVERRUN) count <= count + 5'd1;
          end
        end
        CHECK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPI_FRAME_ERR_EN
  logic read_frame_unused;
  assign read_frame_unused = read_frame;
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: SPI frames at sclk = clk/8 with hand-computed results.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, sclk, ncs, copi;
  logic       valid, read_write, busy;
  logic [6:0] addr;
  logic [7:0] data;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;
  int err_cnt   = 0;
  logic [7:0] data_log[$];

  spi_frame_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi),
    .valid(valid), .read_write(read_write), .addr(addr), .data(data),
`ifdef SPI_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      pulse_cnt++;
      data_log.push_back(data);
    end
`ifdef SPI_FRAME_ERR_EN
    if (frame_err === 1'b1) err_cnt++;
`endif
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [16:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = word[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  // Returns on the falling clk edge at which ncs was just raised.
  task automatic send_frame(input logic [16:0] word, input int nbits);
    wait_clk(1);
    ncs = 1'b0;
    wait_clk(4);
    #1 chk(busy, 1, "busy_in_frame");
    shift_bits(word, nbits);
    wait_clk(4);
    ncs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
    wait_clk(3);
    #1;
    chk(valid, 0, "rst_valid");
    chk(read_write, 0, "rst_rw");
    chk(addr, 0, "rst_addr");
    chk(data, 0, "rst_data");
    chk(busy, 0, "rst_busy");
    rst_n = 1'b1;
    wait_clk(3);

    // Legal write with exact commit latency
    send_frame(17'h084A5, 16);
    @(posedge clk); @(posedge clk);
    #1 chk(valid, 0, "lat_edge2_valid");
    @(posedge clk);
    #1;
    chk(valid, 1, "lat_edge3_valid");
    chk(read_write, 1, "w1_rw");
    chk(addr, 7'h04, "w1_addr");
    chk(data, 8'hA5, "w1_data");
    @(posedge clk);
    #1 chk(valid, 0, "w1_one_cycle");
    wait_clk(4);
    #1;
    chk(pulse_cnt, 1, "w1_pulses");
    chk(busy, 0, "w1_busy_after");

    // Read frame is ignored
    send_frame(17'h004A5, 16);
    wait_clk(10);
    #1;
    chk(pulse_cnt, 1, "read_pulses");
    chk(addr, 7'h04, "read_addr_hold");
    chk(data, 8'hA5, "read_data_hold");
    chk(err_cnt, 0, "read_no_err");

    // Short then overrun frames
    send_frame(17'h00011, 15);
    wait_clk(10);
    send_frame({16'h8011, 1'b1}, 17);
    wait_clk(10);
    #1;
    chk(pulse_cnt, 1, "short_over_pulses");
    chk(data, 8'hA5, "short_over_data_hold");
`ifdef SPI_FRAME_ERR_EN
    chk(err_cnt, 2, "short_over_err");
`endif

    // Address above range, then lowest address
    send_frame(17'h085FF, 16);
    wait_clk(10);
    #1;
    chk(pulse_cnt, 1, "oor_pulses");
    chk(addr, 7'h04, "oor_addr_hold");
`ifdef SPI_FRAME_ERR_EN
    chk(err_cnt, 3, "oor_err");
`endif
    send_frame(17'h08003, 16);
    wait_clk(10);
    #1;
    chk(pulse_cnt, 2, "a0_pulses");
    chk(addr, 7'h00, "a0_addr");
    chk(data, 8'h03, "a0_data");
    chk(read_write, 1, "a0_rw");

    // Back-to-back frames with a 2-cycle ncs gap
    send_frame(17'h08101, 16);
    wait_clk(1);
    send_frame(17'h08202, 16);
    wait_clk(10);
    #1;
    chk(pulse_cnt, 4, "b2b_pulses");
    chk(data_log[2], 8'h01, "b2b_first_data");
    chk(data_log[3], 8'h02, "b2b_second_data");
    chk(addr, 7'h02, "b2b_addr");

    // Reset in mid-frame
    wait_clk(1);
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(17'h00083, 8);
    rst_n = 1'b0;
    #1;
    chk(valid, 0, "midrst_valid");
    chk(read_write, 0, "midrst_rw");
    chk(addr, 0, "midrst_addr");
    chk(data, 0, "midrst_data");
    chk(busy, 0, "midrst_busy");
    ncs = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    #1 chk(pulse_cnt, 4, "midrst_no_pulse");
    send_frame(17'h08377, 16);
    wait_clk(10);
    #1;
    chk(pulse_cnt, 5, "post_rst_pulses");
    chk(addr, 7'h03, "post_rst_addr");
    chk(data, 8'h77, "post_rst_data");
    chk(read_write, 1, "post_rst_rw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
SPI peripheral front end that receives 16-bit frames from an external SPI controller and turns each complete, legal write frame into a one-cycle write request on the register bank's valid/read_write/addr/data bus. Frames use SPI mode 0, MSB first; all SPI pins are asynchronous to clk.
Owns synchronisation, edge detection, bit counting, frame validation and commit sequencing; the register bank stays a purely synchronous write target.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (≥2)
MAX_ADDR, 7'h04, highest register address accepted; frames addressed above it are discarded

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low; one clock, and this is the only reset
sclk  input  1  SPI clock pin, async, idle low
ncs  input  1  SPI chip select pin, active-low, async
copi  input  1  SPI data in, sampled on sclk rising edge
valid  output  1  one-cycle write strobe to register bank
read_write  output  1  frame bit 15; always 1 when valid is high
addr  output  7  frame bits 14:8
data  output  8  frame bits 7:0
busy  output  1  high while a frame is in progress (synchronised ncs low)

Behaviour:
- Reset values: valid=0, read_write=0, addr=0, data=0, busy=0; synchroniser flops reset to idle levels (sclk=0, ncs=1, copi=0); shift register and bit count cleared; state IDLE.
- Each pin passes through a SYNC_STAGES-deep synchroniser, then an edge-detect flop. Rise = sync_out & ~prev.
- SPI timing limits: sclk ≤ clk/4; sclk high and low phases ≥ 2 clk cycles; ncs setup/hold to the first/last sclk edge ≥ 2 clk cycles.
- States:
  - IDLE: synchronised ncs low → SHIFT; bit count and shift register cleared.
  - SHIFT: each synchronised sclk rise shifts synchronised copi into bit 0 of a 16-bit shift register. The bit count increments and saturates at 17, which means overrun. A synchronised ncs rise → CHECK.
  - CHECK (one cycle): the frame is legal when count==16, bit15==1 and bits14:8 ≤ MAX_ADDR. A legal frame is committed. Always returns to IDLE.
- Commit: addr, data and read_write are registered from the shift register, and valid is driven high for exactly one cycle, all on the same clk edge.
  - With SYNC_STAGES=2, valid is high in the cycle after the 3rd rising clk edge, counting the edge that first samples ncs=1 at the pin as edge 1.
  - addr, data and read_write hold their values until the next commit.
- Discarded frames leave valid, addr, data and read_write unchanged:
  - short frame (count<16)
  - overrun (count=17)
  - read frame (bit15=0)
  - address above MAX_ADDR
- sclk edges while synchronised ncs is high are ignored. A synchronised sclk rise in the same cycle as a synchronised ncs rise is not counted.
- ncs low for zero sclk edges is a short frame; nothing is committed.
- busy tracks synchronised ncs inverted (high in SHIFT).
- rst_n asserted mid-frame: everything clears at once and the partial frame is lost. After release, the block waits in IDLE for the next ncs fall. If ncs is already low at release, that frame is received from its current bit, will not be 16 bits, and is discarded.

Optional Feature:
SPI_FRAME_ERR_EN
- Defined: adds output frame_err (1 bit, reset 0). It pulses high for one cycle in the cycle valid would have pulsed, for short, overrun and out-of-range-address frames. Read frames do not raise frame_err.
- Undefined: the port and its logic are absent; discard behaviour is otherwise identical.

Decomposition:
- Shared package spi_pkg:
  - FRAME_BITS=16
  - field positions RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7
  - register address constants ADDR_EN_OUT_7_0=0x00 through ADDR_PWM_DUTY=0x04
  - state enum IDLE/SHIFT/CHECK
- Sub-module spi_sync: parameterised synchroniser plus edge detector with outputs level, rise and fall. It is instantiated three times (sclk, ncs, copi; copi uses level only).

Test Plan:
- Frame 16'h84A5 at sclk=clk/8 → one valid pulse, read_write=1, addr=7'h04, data=8'hA5, at the required latency after ncs rise; outputs hold afterwards.
- Read frame 16'h04A5 → no valid pulse; addr/data keep their previous values; frame_err stays 0 under SPI_FRAME_ERR_EN.
- 15-bit frame, then 17-bit frame with the legal prefix 16'h8011 → no valid for either; two frame_err pulses under SPI_FRAME_ERR_EN.
- Frame 16'h85FF (addr 0x05 > MAX_ADDR) → no valid; then 16'h8003 → valid with addr=7'h00, data=8'h03.
- Back-to-back frames 16'h8101, 16'h8202 with 2-cycle ncs high gap → two valid pulses in order, data 8'h01 then 8'h02.
- rst_n pulsed low after 8 bits of 16'h8377 → all outputs 0 at once, no valid; the next full frame 16'h8377 → valid with addr=7'h03, data=8'h77.
